// File: rtl/layer_1_5_sequencer.sv
// -----------------------------------------------------------------------------
// layer_1_5_sequencer
//   Control sequencer for the layer-1 5-neuron masked MAC datapath.
//   A pass clears the accumulators, streams N_INPUTS pixel/weight reads,
//   waits two cycles for the datapath to drain, then presents result_valid
//   until the consumer acknowledges. abort cancels a pass from any busy state.
//
// Ports
//   clk            in   clock, all flops on posedge
//   reset          in   asynchronous active-low reset
//   start          in   begin a pass (sampled only in IDLE)
//   abort          in   cancel the pass (sampled in every non-IDLE state)
//   image_bit      in   pixel bit, valid one cycle after rd_en
//   result_ack     in   consumer accepted the result
//   rd_en          out  read strobe to image buffer and weight ROM
//   pixel_addr     out  pixel index / weight ROM address
//   mac_clear      out  synchronous clear to datapath accumulators
//   mac_load       out  datapath input-register load
//   mac_accumulate out  datapath accumulate flag (same as mac_load)
//   mac_mask       out  datapath mask bit (image_bit passed through)
//   busy           out  high in every state except IDLE
//   result_valid   out  accumulators final, held until result_ack
// -----------------------------------------------------------------------------
module layer_1_5_sequencer #(
  parameter int N_INPUTS = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              image_bit,
  input  logic              result_ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              mac_clear,
  output logic              mac_load,
  output logic              mac_accumulate,
  output logic              mac_mask,
  output logic              busy,
  output logic              result_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_ABORT  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_drain;
  logic              r_rd_v;
  logic              w_last;

  assign w_last = (r_addr == LAST_ADDR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  w_next = abort ? S_ABORT : S_STREAM;
      S_STREAM: begin
        if (abort)       w_next = S_ABORT;
        else if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)        w_next = S_ABORT;
        else if (r_drain) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (abort)           w_next = S_ABORT;
        else if (result_ack) w_next = S_IDLE;
      end
      S_ABORT:  w_next = abort ? S_ABORT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_drain <= 1'b0;
      r_rd_v  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_v  <= rd_en;
      // Second DRAIN cycle is marked by r_drain; it is zero on DRAIN entry.
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
      // Address saturates at the last pixel and is rearmed to 0 outside a pass.
      if (r_state == S_STREAM) begin
        if (!w_last) r_addr <= r_addr + 1'b1;
      end else if ((r_state == S_IDLE) || (r_state == S_CLEAR) ||
                   (r_state == S_ABORT)) begin
        r_addr <= '0;
      end
    end
  end

  assign rd_en          = (r_state == S_STREAM);
  assign pixel_addr     = r_addr;
  assign mac_clear      = (r_state == S_CLEAR) || (r_state == S_ABORT);
  // The read issued in the aborting STREAM cycle is suppressed here.
  assign mac_load       = r_rd_v && (r_state != S_ABORT);
  assign mac_accumulate = mac_load;
  assign mac_mask       = image_bit;
  assign busy           = (r_state != S_IDLE);
  assign result_valid   = (r_state == S_HOLD);

endmodule

// File: tb/tb_layer_1_5_sequencer.sv
module tb_layer_1_5_sequencer;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       start, abort, image_bit, result_ack;
  logic       rd_en, mac_clear, mac_load, mac_accumulate, mac_mask, busy, result_valid;
  logic [2:0] pixel_addr;

  logic       b_start, b_abort, b_image_bit, b_ack;
  logic       b_rd_en, b_clear, b_load, b_accum, b_mask, b_busy, b_rv;
  logic [7:0] b_addr;

  int vectors = 0;
  int miscompares = 0;

  // Reference image / weight ROM for the small instance.
  logic [N-1:0] img;
  logic [7:0]   rom [N];
  logic [7:0]   w_q;
  logic [15:0]  acc;

  layer_1_5_sequencer #(.N_INPUTS(N), .ADDR_W(3)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .image_bit(image_bit), .result_ack(result_ack), .rd_en(rd_en),
    .pixel_addr(pixel_addr), .mac_clear(mac_clear), .mac_load(mac_load),
    .mac_accumulate(mac_accumulate), .mac_mask(mac_mask), .busy(busy),
    .result_valid(result_valid)
  );

  layer_1_5_sequencer #(.N_INPUTS(256), .ADDR_W(8)) u_big (
    .clk(clk), .reset(rst_n), .start(b_start), .abort(b_abort),
    .image_bit(b_image_bit), .result_ack(b_ack), .rd_en(b_rd_en),
    .pixel_addr(b_addr), .mac_clear(b_clear), .mac_load(b_load),
    .mac_accumulate(b_accum), .mac_mask(b_mask), .busy(b_busy),
    .result_valid(b_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered image buffer + weight ROM.
  always @(posedge clk) begin
    if (rd_en) begin
      image_bit <= img[pixel_addr];
      w_q       <= rom[pixel_addr];
    end
  end

  // Neuron-0 datapath: weight sign-extended with 4 fraction bits into 16 bits.
  always @(posedge clk) begin
    if (mac_clear)                  acc <= 16'h0000;
    else if (mac_load && mac_mask)  acc <= acc + {{4{w_q[7]}}, w_q, 4'b0000};
  end

  function automatic logic [15:0] ref_acc();
    int s = 0;
    for (int i = 0; i < N; i++)
      if (img[i]) s += $signed(rom[i]) * 16;
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full pass from IDLE: checks schedule, load count, latency, result and hold.
  task automatic do_pass(input string tag, input logic [15:0] exp_acc);
    int clr_cnt = 0, rd_cnt = 0, ld_cnt = 0, bad = 0, rv_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (result_valid) begin rv_at = cyc; break; end
      if (mac_clear) begin clr_cnt++; if (cyc != 0) bad++; end
      if (rd_en) begin rd_cnt++; if (pixel_addr != 3'(cyc - 1)) bad++; end
      if (mac_load) begin
        ld_cnt++;
        if (cyc < 2 || cyc > N + 1) bad++;
        if (mac_accumulate !== 1'b1) bad++;
      end
      if (!busy) bad++;
      tick();
    end
    chk({tag, " clear_cycles"}, clr_cnt, 1);
    chk({tag, " reads"}, rd_cnt, N);
    chk({tag, " loads"}, ld_cnt, N);
    chk({tag, " schedule_errors"}, bad, 0);
    chk({tag, " rv_latency"}, rv_at, N + 3);
    chk({tag, " acc"}, acc, exp_acc);
    for (int i = 0; i < 5; i++) begin
      chk({tag, " hold_rv"}, result_valid, 1);
      chk({tag, " hold_acc"}, acc, exp_acc);
      tick();
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk({tag, " rv_after_ack"}, result_valid, 0);
    chk({tag, " busy_after_ack"}, busy, 0);
  endtask

  initial begin
    int seen, ld_cnt, rv_at, clr_cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ack = 1'b0;
    image_bit = 1'b0; w_q = 8'h00; acc = 16'h0000; img = '0;
    for (int i = 0; i < N; i++) rom[i] = 8'h00;
    b_start = 1'b0; b_abort = 1'b0; b_image_bit = 1'b0; b_ack = 1'b0;
    #2;
    chk("rst rd_en", rd_en, 0);
    chk("rst addr", pixel_addr, 0);
    chk("rst clear", mac_clear, 0);
    chk("rst load", mac_load, 0);
    chk("rst busy", busy, 0);
    chk("rst rv", result_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Directed: mask 1,0,1,1 with weights 10,20,30,01.
    img = 4'b1101;
    rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h30; rom[3] = 8'h01;
    do_pass("dir_pos", 16'h0410);

    // Directed: negative weight at pixel 0 only.
    img = 4'b0001;
    rom[0] = 8'hF0; rom[1] = 8'h7F; rom[2] = 8'h55; rom[3] = 8'h80;
    do_pass("dir_neg", 16'hFF00);

    // Random images and weights against the arithmetic reference.
    for (int p = 0; p < 6; p++) begin
      img = 4'($urandom);
      for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
      do_pass("rand", ref_acc());
    end

    // Abort sampled at E3, mid-STREAM.
    img = 4'b1111;
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
    start = 1'b1; tick(); start = 1'b0;   // E0
    tick(); tick();                         // E1, E2
    abort = 1'b1; tick(); abort = 1'b0;    // E3
    chk("abort clear", mac_clear, 1);
    chk("abort load_blocked", mac_load, 0);
    chk("abort busy", busy, 1);
    chk("abort rv", result_valid, 0);
    tick();
    chk("abort clear_one_cycle", mac_clear, 0);
    chk("abort idle", busy, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid || busy || mac_load) seen++;
      tick();
    end
    chk("abort quiet", seen, 0);
    do_pass("after_abort", ref_acc());

    // start held high through the pass, then start together with ack.
    img = 4'($urandom);
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
    start = 1'b1;
    clr_cnt = 0; rv_at = -1;
    tick();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (result_valid) begin rv_at = cyc; break; end
      if (mac_clear) clr_cnt++;
      tick();
    end
    chk("held_start latency", rv_at, N + 3);
    tick(); tick();
    chk("held_start still_hold", result_valid, 1);
    chk("held_start one_clear", clr_cnt, 1);
    chk("held_start acc", acc, ref_acc());
    result_ack = 1'b1;
    tick();
    start = 1'b0; result_ack = 1'b0;
    chk("start_ack idle", busy, 0);
    chk("start_ack rv", result_valid, 0);
    tick();
    chk("start_ack no_new_pass", busy, 0);
    chk("start_ack no_clear", mac_clear, 0);

    // Asynchronous reset mid-STREAM.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_reset streaming", rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst rd_en", rd_en, 0);
    chk("async_rst addr", pixel_addr, 0);
    chk("async_rst clear", mac_clear, 0);
    chk("async_rst load", mac_load, 0);
    chk("async_rst busy", busy, 0);
    chk("async_rst rv", result_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    img = 4'($urandom);
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
    do_pass("after_reset", ref_acc());

    // Full-size instance: 256 loads, result_valid at E259.
    b_start = 1'b1; tick(); b_start = 1'b0;
    ld_cnt = 0; rv_at = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (b_rv) begin rv_at = cyc; break; end
      if (b_load) ld_cnt++;
      b_image_bit = 1'($urandom);
      tick();
    end
    chk("big loads", ld_cnt, 256);
    chk("big rv_latency", rv_at, 259);
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    chk("big idle_after_ack", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
